// File: rtl/stat_bist_ctrl_if.sv
// Harness-side bundle for the BIST sequencer: control handshake,
// functional vectors and the netlist input/output buses.
interface stat_bist_ctrl_if #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 19,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] pat_count;
  logic [IN_W-1:0]  func_in;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [OUT_W-1:0] func_out;
  logic             func_valid;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] signature;
  logic [CNT_W-1:0] pat_idx;

  modport master (
    output start, abort, pat_count, func_in, dut_out,
    input  dut_in, func_out, func_valid, busy, done,
    input  signature, pat_idx
  );

  modport slave (
    input  start, abort, pat_count, func_in, dut_out,
    output dut_in, func_out, func_valid, busy, done,
    output signature, pat_idx
  );
endinterface

// File: rtl/stat_bist_ctrl.sv
// BIST sequencer: LFSR pattern source, settle/capture timing and
// MISR response compaction for one combinational netlist.
module stat_bist_ctrl #(
  parameter int            IN_W      = 21,
  parameter int            OUT_W     = 19,
  parameter int            CNT_W     = 16,
  parameter logic [IN_W-1:0] LFSR_SEED = 21'h000001,
  parameter int            SETTLE    = 1
) (
  input  logic           clk,
  input  logic           rst,
  stat_bist_ctrl_if.slave bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IN_W-1:0]  r_lfsr;
  logic [OUT_W-1:0] r_misr;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_n;
  logic [SW-1:0]    r_settle;

  logic             w_load;
  logic             w_zero;
  logic             w_cap;
  logic             w_last;
  logic             w_busy;
  logic             w_fb;

  assign w_last = (r_idx == r_n - 1'b1);
  assign w_fb   = r_misr[OUT_W-1] ^ r_misr[5] ^ r_misr[1] ^ r_misr[0];
  assign w_busy = (r_state == S_APPLY) || (r_state == S_CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // abort wins over everything, including a same-cycle start
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_zero = 1'b0;
    w_cap  = 1'b0;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.pat_count != '0) begin
              w_load = 1'b1;
              w_next = S_APPLY;
            end else begin
              w_zero = 1'b1;
              w_next = S_DONE;
            end
          end
        end
        S_APPLY: begin
          if (r_settle == SW'(SETTLE - 1)) w_next = S_CAPTURE;
        end
        S_CAPTURE: begin
          w_cap  = 1'b1;
          w_next = w_last ? S_DONE : S_APPLY;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr   <= LFSR_SEED;
      r_misr   <= '0;
      r_idx    <= '0;
      r_n      <= '0;
      r_settle <= '0;
    end else if (w_load) begin
      r_n      <= bus.pat_count;
      r_lfsr   <= LFSR_SEED;
      r_misr   <= '0;
      r_idx    <= '0;
      r_settle <= '0;
    end else if (w_zero) begin
      r_misr <= '0;
    end else if (w_cap) begin
      r_misr <= {r_misr[OUT_W-2:0], w_fb} ^ bus.dut_out;
      r_lfsr <= {r_lfsr[IN_W-2:0], r_lfsr[IN_W-1] ^ r_lfsr[IN_W-3]};
      if (!w_last) begin
        r_idx    <= r_idx + 1'b1;
        r_settle <= '0;
      end
    end else if (r_state == S_APPLY && !bus.abort) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  assign bus.dut_in     = w_busy ? r_lfsr : bus.func_in;
  assign bus.func_out   = bus.dut_out;
  assign bus.func_valid = !w_busy;
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == S_DONE);
  assign bus.signature  = r_misr;
  assign bus.pat_idx    = r_idx;

endmodule

// File: tb/tb_stat_bist_ctrl.sv
// Bench for stat_bist_ctrl: netlist stand-in, pattern/signature
// reference model and directed + randomized run sequence.
module tb_stat_bist_ctrl;

  localparam int S = 1;
  localparam logic [20:0] SEED = 21'h000001;

  logic clk;
  logic rst;
  logic [1:0] nl_mode;
  int vectors;
  int errs;

  stat_bist_ctrl_if #(.IN_W(21), .OUT_W(19), .CNT_W(16)) bus ();

  stat_bist_ctrl #(
    .IN_W(21), .OUT_W(19), .CNT_W(16),
    .LFSR_SEED(SEED), .SETTLE(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] net(input logic [20:0] v,
                                      input logic [1:0] m);
    case (m)
      2'd0:    return 19'h0;
      2'd1:    return 19'h1;
      default: return v[18:0] ^ v[20:2] ^ 19'h2A5A5;
    endcase
  endfunction

  always_comb bus.dut_out = net(bus.dut_in, nl_mode);

  function automatic logic [20:0] lfsr_nx(input logic [20:0] v);
    return {v[19:0], v[20] ^ v[18]};
  endfunction

  // signature after n captures: shift-left MISR, taps x19+x6+x2+x1
  function automatic logic [18:0] model_sig(input int n,
                                            input logic [1:0] m);
    logic [20:0] p;
    logic [18:0] s;
    logic [18:0] taps;
    p = SEED;
    s = '0;
    taps = 19'h40023;
    for (int i = 0; i < n; i++) begin
      s = {s[17:0], ^(s & taps)} ^ net(p, m);
      p = lfsr_nx(p);
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] n);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.pat_count = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.pat_count = 16'($urandom);
  endtask

  task automatic run(input int n, input logic [1:0] m,
                     input int abort_at);
    logic [20:0] p;
    int bc;
    int k;
    bit aborted;
    nl_mode = m;
    pulse_start(16'(n));
    p = SEED;
    bc = 0;
    k = 0;
    aborted = 0;
    for (int c = 0; c < 2 * n * (S + 1) + 10; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (c / (S + 1) != k) begin
        k++;
        p = lfsr_nx(p);
      end
      chk("pattern", 64'(bus.dut_in), 64'(p));
      chk("pat_idx", 64'(bus.pat_idx), 64'(k));
      chk("func_valid_busy", 64'(bus.func_valid), 64'd0);
      bc++;
      if (abort_at >= 0 && k == abort_at) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.pat_count = 16'd5;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_dut_in", 64'(bus.dut_in), 64'(bus.func_in));
        chk("abort_idx", 64'(bus.pat_idx), 64'(abort_at));
        chk("abort_sig", 64'(bus.signature),
            64'(model_sig(abort_at, m)));
        @(negedge clk);
        chk("abort_idle", 64'({bus.busy, bus.done}), 64'd0);
        aborted = 1;
        break;
      end
      bus.start = 1'($urandom);
      bus.pat_count = 16'($urandom);
      bus.func_in = 21'($urandom);
    end
    bus.start = 1'b0;
    if (!aborted) begin
      chk("busy_cycles", 64'(bc), 64'(n * (S + 1)));
      chk("done", 64'(bus.done), 64'd1);
      chk("signature", 64'(bus.signature), 64'(model_sig(n, m)));
      chk("dut_in_func", 64'(bus.dut_in), 64'(bus.func_in));
      chk("func_valid", 64'(bus.func_valid), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    errs = 0;
    nl_mode = 2'd2;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pat_count = '0;
    bus.func_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.func_in = 21'h15A5A5;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sig", 64'(bus.signature), 64'd0);
    chk("rst_idx", 64'(bus.pat_idx), 64'd0);
    chk("pass_dut_in", 64'(bus.dut_in), 64'h15A5A5);
    chk("pass_valid", 64'(bus.func_valid), 64'd1);
    chk("pass_out", 64'(bus.func_out),
        64'(net(21'h15A5A5, 2'd2)));
    for (int i = 0; i < 6; i++) begin
      bus.func_in = 21'($urandom);
      @(negedge clk);
      chk("pass_rand_in", 64'(bus.dut_in), 64'(bus.func_in));
      chk("pass_rand_out", 64'(bus.func_out),
          64'(net(bus.func_in, 2'd2)));
    end

    run(3, 2'd0, -1);
    run(1, 2'd1, -1);
    chk("misr_n1", 64'(bus.signature), 64'h1);
    run(2, 2'd1, -1);
    chk("misr_n2", 64'(bus.signature), 64'h2);

    pulse_start(16'd0);
    @(negedge clk);
    chk("zero_busy", 64'(bus.busy), 64'd0);
    chk("zero_done", 64'(bus.done), 64'd1);
    chk("zero_sig", 64'(bus.signature), 64'd0);

    run(100, 2'd2, 10);
    run(100, 2'd2, -1);

    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 40), 2'd2, -1);
    end

    nl_mode = 2'd2;
    pulse_start(16'd5);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_sig", 64'(bus.signature), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_dut_in", 64'(bus.dut_in), 64'(bus.func_in));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", 64'({bus.busy, bus.done}), 64'd0);
    chk("arst_idx", 64'(bus.pat_idx), 64'd0);
    chk("arst_sig2", 64'(bus.signature), 64'd0);

    run(4, 2'd2, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
